// File: rtl/tt_um_seq_divider_8x4.sv
// Sequential restoring divider (8-bit dividend / 4-bit divisor) in the TinyTapeout user-tile pinout.
// Optional feature macro: DIV_ZERO_FLAG_EN exposes the divide-by-zero flag on uo_out[7] in remainder view.
module tt_um_seq_divider_8x4 #(
   parameter int N_BITS = 8,
   parameter int D_BITS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   output logic [7:0] uo_out
);

   localparam int CW = $clog2(N_BITS);
   localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [N_BITS-1:0]   r_dvd;
   logic [D_BITS-1:0]   r_dvs;
   logic [D_BITS-1:0]   r_rem_acc;
   logic [N_BITS-1:0]   r_qacc;
   logic [N_BITS-1:0]   r_quot;
   logic [D_BITS-1:0]   r_rem;
   logic [CW-1:0]       r_count;
   logic                r_start_q;
   logic                r_busy;
   logic                r_done;

   logic                w_start;
   logic                w_sel;
   logic [D_BITS-1:0]   w_dvs_in;
   logic                w_launch;
   logic                w_accept;
   logic                w_dz_finish;
   logic [D_BITS:0]     w_trial;
   logic [D_BITS:0]     w_diff;
   logic                w_ge;
   logic [D_BITS-1:0]   w_rem_next;
   logic [N_BITS-1:0]   w_q_next;
   logic                w_flag;
   logic                w_unused;

   assign w_start     = uio_in[4];
   assign w_sel       = uio_in[5];
   assign w_dvs_in    = uio_in[D_BITS-1:0];
   assign w_launch    = w_start & ~r_start_q;
   assign w_accept    = w_launch && (r_state != S_CALC);
   // A divide-by-zero launch spends one busy cycle in DONE before publishing its result.
   assign w_dz_finish = (r_state == S_DONE) && r_busy && !w_launch;

   // The trial value is one bit wider than the divisor so the compare cannot overflow;
   // the stored partial remainder always fits in D_BITS because it is below the divisor.
   assign w_trial    = {r_rem_acc, r_dvd[N_BITS-1]};
   assign w_diff     = w_trial - {1'b0, r_dvs};
   assign w_ge       = (w_trial >= {1'b0, r_dvs});
   assign w_rem_next = w_ge ? w_diff[D_BITS-1:0] : w_trial[D_BITS-1:0];
   assign w_q_next   = {r_qacc[N_BITS-2:0], w_ge};

   assign w_unused   = &{1'b0, uio_in[7:6], w_diff[D_BITS], 1'b0};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else if (ena) begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept) begin
               w_state_next = (w_dvs_in == '0) ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (r_count == LAST) begin
               w_state_next = S_DONE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_dvd     <= '0;
         r_dvs     <= '0;
         r_rem_acc <= '0;
         r_qacc    <= '0;
         r_quot    <= '0;
         r_rem     <= '0;
         r_count   <= '0;
         r_start_q <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else if (ena) begin
         r_start_q <= w_start;
         if (w_accept) begin
            r_dvd     <= ui_in[N_BITS-1:0];
            r_dvs     <= w_dvs_in;
            r_rem_acc <= '0;
            r_qacc    <= '0;
            r_count   <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
         end else if (w_dz_finish) begin
            r_quot <= '1;
            r_rem  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b1;
         end else if (r_state == S_CALC) begin
            r_rem_acc <= w_rem_next;
            r_qacc    <= w_q_next;
            r_dvd     <= {r_dvd[N_BITS-2:0], 1'b0};
            r_count   <= r_count + 1'b1;
            if (r_count == LAST) begin
               r_quot <= w_q_next;
               r_rem  <= w_rem_next;
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

`ifdef DIV_ZERO_FLAG_EN
   logic r_dz;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_dz <= 1'b0;
      end else if (ena) begin
         if (w_accept) begin
            r_dz <= 1'b0;
         end else if (w_dz_finish) begin
            r_dz <= 1'b1;
         end
      end
   end

   assign w_flag = r_dz;
`else
   assign w_flag = 1'b0;
`endif

   assign uio_out = {r_done, r_busy, 6'b00_0000};
   assign uio_oe  = 8'b1100_0000;
   assign uo_out  = w_sel ? {w_flag, {(7 - D_BITS){1'b0}}, r_rem} : r_quot;

endmodule

// File: tb/tb_tt_um_seq_divider_8x4.sv
// Self-checking bench for tt_um_seq_divider_8x4: scoreboard of expected quotient/remainder
// pushed at launch and popped when done rises; honours DIV_ZERO_FLAG_EN for the remainder view.
module tb_tt_um_seq_divider_8x4;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;
   logic [7:0] uo_out;

   logic       start;
   logic       sel;
   logic [3:0] dvs_drv;

   typedef struct packed {
      logic [7:0] q;
      logic [3:0] r;
      logic       dz;
   } exp_t;

   exp_t       sb[$];
   int         checks;
   int         failures;
   logic [7:0] last_q;

   assign uio_in = {2'b00, sel, start, dvs_drv};

   tt_um_seq_divider_8x4 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe),
      .uo_out  (uo_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: plain integer division, with the divide-by-zero convention.
   function automatic exp_t model(input logic [7:0] dvd, input logic [3:0] dvs);
      exp_t e;
      if (dvs == 4'd0) begin
         e.q  = 8'hFF;
         e.r  = 4'h0;
         e.dz = 1'b1;
      end else begin
         e.q  = 8'(int'(dvd) / int'(dvs));
         e.r  = 4'(int'(dvd) % int'(dvs));
         e.dz = 1'b0;
      end
      return e;
   endfunction

   function automatic logic [7:0] rem_view(input exp_t e);
`ifdef DIV_ZERO_FLAG_EN
      return {e.dz, 3'b000, e.r};
`else
      return {4'b0000, e.r};
`endif
   endfunction

   // Drives a one-cycle start pulse; returns at the falling edge just after the launch edge.
   task automatic launch(input logic [7:0] dvd, input logic [3:0] dvs);
      @(negedge clk);
      ui_in   = dvd;
      dvs_drv = dvs;
      start   = 1'b1;
      sb.push_back(model(dvd, dvs));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (uio_out[7] !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      ena     = 1'b1;
      start   = 1'b0;
      sel     = 1'b0;
      dvs_drv = 4'd0;
      ui_in   = 8'd0;
      repeat (3) @(negedge clk);
      checks++;
      if (uio_out !== 8'h00) begin
         failures++;
         $display("[TB] FAIL reset_uio_out: got %h expected 00", uio_out);
      end
      checks++;
      if (uo_out !== 8'h00) begin
         failures++;
         $display("[TB] FAIL reset_quot_view: got %h expected 00", uo_out);
      end
      sel = 1'b1;
      #1;
      checks++;
      if (uo_out !== 8'h00) begin
         failures++;
         $display("[TB] FAIL reset_rem_view: got %h expected 00", uo_out);
      end
      sel = 1'b0;
      checks++;
      if (uio_oe !== 8'hC0) begin
         failures++;
         $display("[TB] FAIL uio_oe: got %h expected c0", uio_oe);
      end
      rst_n  = 1'b1;
      last_q = 8'h00;
      @(negedge clk);
   endtask

   task automatic test_divide(input logic [7:0] dvd, input logic [3:0] dvs);
      int   cyc;
      int   lat;
      exp_t e;
      lat = (dvs == 4'd0) ? 1 : 8;
      launch(dvd, dvs);
      checks++;
      if (uio_out[7:6] !== 2'b01) begin
         failures++;
         $display("[TB] FAIL launch_flags %0d/%0d: got done,busy=%b expected 01", dvd, dvs, uio_out[7:6]);
      end
      checks++;
      if (uo_out !== last_q) begin
         failures++;
         $display("[TB] FAIL prev_result_while_busy %0d/%0d: got %h expected %h", dvd, dvs, uo_out, last_q);
      end
      wait_done(cyc);
      checks++;
      if (cyc !== lat) begin
         failures++;
         $display("[TB] FAIL latency %0d/%0d: got %0d expected %0d", dvd, dvs, cyc, lat);
      end
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_empty %0d/%0d: got 0 entries expected 1", dvd, dvs);
      end else begin
         e = sb.pop_front();
         checks++;
         if (uo_out !== e.q) begin
            failures++;
            $display("[TB] FAIL quotient %0d/%0d: got %h expected %h", dvd, dvs, uo_out, e.q);
         end
         sel = 1'b1;
         #1;
         checks++;
         if (uo_out !== rem_view(e)) begin
            failures++;
            $display("[TB] FAIL remainder_view %0d/%0d: got %h expected %h", dvd, dvs, uo_out, rem_view(e));
         end
         sel    = 1'b0;
         last_q = e.q;
      end
   endtask

   task automatic test_relaunch_ignored();
      int   cyc;
      exp_t e;
      launch(8'd100, 4'd3);
      repeat (2) @(negedge clk);
      ui_in = 8'd50;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc);
      checks++;
      if (3 + cyc !== 8) begin
         failures++;
         $display("[TB] FAIL relaunch_latency: got %0d expected 8", 3 + cyc);
      end
      e = sb.pop_front();
      checks++;
      if (uo_out !== e.q) begin
         failures++;
         $display("[TB] FAIL relaunch_quotient: got %h expected %h", uo_out, e.q);
      end
      sel = 1'b1;
      #1;
      checks++;
      if (uo_out !== rem_view(e)) begin
         failures++;
         $display("[TB] FAIL relaunch_remainder: got %h expected %h", uo_out, rem_view(e));
      end
      sel = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (uio_out[7:6] !== 2'b10) begin
         failures++;
         $display("[TB] FAIL relaunch_stays_done: got done,busy=%b expected 10", uio_out[7:6]);
      end
      last_q = e.q;
   endtask

   task automatic test_reset_mid_calc();
      launch(8'd225, 4'd15);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      void'(sb.pop_back());
      checks++;
      if (uio_out[7:6] !== 2'b00) begin
         failures++;
         $display("[TB] FAIL midreset_flags: got done,busy=%b expected 00", uio_out[7:6]);
      end
      checks++;
      if (uo_out !== 8'h00) begin
         failures++;
         $display("[TB] FAIL midreset_quot_view: got %h expected 00", uo_out);
      end
      sel = 1'b1;
      #1;
      checks++;
      if (uo_out !== 8'h00) begin
         failures++;
         $display("[TB] FAIL midreset_rem_view: got %h expected 00", uo_out);
      end
      sel    = 1'b0;
      rst_n  = 1'b1;
      last_q = 8'h00;
      test_divide(8'd225, 4'd15);
   endtask

   task automatic test_start_held();
      int   cyc;
      int   busy_seen;
      exp_t e;
      @(negedge clk);
      ui_in   = 8'd60;
      dvs_drv = 4'd5;
      start   = 1'b1;
      sb.push_back(model(8'd60, 4'd5));
      @(negedge clk);
      wait_done(cyc);
      checks++;
      if (cyc !== 8) begin
         failures++;
         $display("[TB] FAIL held_latency: got %0d expected 8", cyc);
      end
      e = sb.pop_front();
      ui_in     = 8'd30;
      dvs_drv   = 4'd3;
      busy_seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (uio_out[6] === 1'b1) busy_seen++;
      end
      checks++;
      if (busy_seen !== 0) begin
         failures++;
         $display("[TB] FAIL held_no_relaunch: got %0d busy cycles expected 0", busy_seen);
      end
      checks++;
      if (uo_out !== e.q) begin
         failures++;
         $display("[TB] FAIL held_quotient: got %h expected %h", uo_out, e.q);
      end
      start = 1'b0;
      @(negedge clk);
      last_q = e.q;
      test_divide(8'd20, 4'd4);
   endtask

   task automatic test_ena_stall();
      int   cyc;
      int   bad;
      exp_t e;
      launch(8'd200, 4'd7);
      repeat (2) @(negedge clk);
      ena = 1'b0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (uio_out[7:6] !== 2'b01) bad++;
      end
      ena = 1'b1;
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("[TB] FAIL stall_busy_held: got %0d bad cycles expected 0", bad);
      end
      wait_done(cyc);
      checks++;
      if (7 + cyc !== 13) begin
         failures++;
         $display("[TB] FAIL stall_latency: got %0d expected 13", 7 + cyc);
      end
      e = sb.pop_front();
      checks++;
      if (uo_out !== e.q) begin
         failures++;
         $display("[TB] FAIL stall_quotient: got %h expected %h", uo_out, e.q);
      end
      sel = 1'b1;
      #1;
      checks++;
      if (uo_out !== rem_view(e)) begin
         failures++;
         $display("[TB] FAIL stall_remainder: got %h expected %h", uo_out, rem_view(e));
      end
      sel    = 1'b0;
      last_q = e.q;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_divide(8'd225, 4'd15);
      test_divide(8'd200, 4'd7);
      test_divide(8'd6, 4'd9);
      test_divide(8'd255, 4'd1);
      test_divide(8'd6, 4'd0);
      test_divide(8'd17, 4'd15);
      test_relaunch_ignored();
      test_reset_mid_calc();
      test_start_held();
      test_ena_stall();
      for (int i = 0; i < 6; i++) begin
         test_divide(8'($urandom_range(0, 255)), 4'($urandom_range(1, 15)));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
